// File: rtl/dmem_responder.sv
// Data-memory target with programmable wait states, byte-lane writes and a one-cycle ready pulse per access.
// Optional DMEM_RANGE_CHECK_EN adds o_data_err for out-of-range addresses and simultaneous read/write.
module dmem_responder #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_data_rd_en,
   input  logic                    i_data_wr_en,
   input  logic [31:0]             i_data_addr,
   input  logic [DATA_WIDTH-1:0]   i_data_wr,
   input  logic [DATA_WIDTH/8-1:0] i_data_be,
   output logic [DATA_WIDTH-1:0]   o_data_rd,
`ifdef DMEM_RANGE_CHECK_EN
   output logic                    o_data_err,
`endif
   output logic                    o_data_ready
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned NB = DATA_WIDTH / 8;
   localparam int unsigned CW = 4;
   localparam logic [CW-1:0] WS_LOAD = (WAIT_STATES == 0) ? CW'(0) : CW'(WAIT_STATES - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                state, state_nxt;
   logic [CW-1:0]         cnt, cnt_nxt;
   logic                  ready_c;
   logic                  commit_c;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  req;
   logic [AW-1:0]         in_idx;
   logic                  in_oor;

   logic [AW-1:0]         cap_idx;
   logic [DATA_WIDTH-1:0] cap_wdata;
   logic [NB-1:0]         cap_be;
   logic                  cap_wr;
   logic                  cap_oor;

   logic [AW-1:0]         acc_idx;
   logic [DATA_WIDTH-1:0] acc_wdata;
   logic [NB-1:0]         acc_be;
   logic                  acc_wr;
   logic                  acc_oor;

   logic                  unused_addr;

   assign req         = i_data_rd_en | i_data_wr_en;
   assign in_idx      = i_data_addr[AW+1:2];
   assign unused_addr = ^{i_data_addr[31:AW+2], i_data_addr[1:0]};

`ifdef DMEM_RANGE_CHECK_EN
   logic in_err;
   logic cap_err;
   logic acc_err;
   assign in_oor  = |i_data_addr[31:AW+2];
   assign in_err  = in_oor | (i_data_rd_en & i_data_wr_en);
   assign acc_err = (state == IDLE) ? in_err : cap_err;
`else
   assign in_oor = 1'b0;
`endif

   // With zero wait states the commit edge is the capture edge, so use live inputs in IDLE.
   assign acc_idx   = (state == IDLE) ? in_idx       : cap_idx;
   assign acc_wdata = (state == IDLE) ? i_data_wr    : cap_wdata;
   assign acc_be    = (state == IDLE) ? i_data_be    : cap_be;
   assign acc_wr    = (state == IDLE) ? i_data_wr_en : cap_wr;
   assign acc_oor   = (state == IDLE) ? in_oor       : cap_oor;

   // Next-state, wait counter and ready generation.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ready_c   = 1'b0;
      commit_c  = 1'b0;
      case (state)
         IDLE: begin
            ready_c = ~req;
            if (req) begin
               if (WAIT_STATES == 0) begin
                  state_nxt = DONE;
                  commit_c  = 1'b1;
               end else begin
                  state_nxt = BUSY;
                  cnt_nxt   = WS_LOAD;
               end
            end
         end
         BUSY: begin
            if (cnt == CW'(0)) begin
               state_nxt = DONE;
               commit_c  = 1'b1;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         DONE: begin
            ready_c   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign o_data_ready = ready_c & ~rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         cap_idx   <= '0;
         cap_wdata <= '0;
         cap_be    <= '0;
         cap_wr    <= 1'b0;
         cap_oor   <= 1'b0;
         o_data_rd <= '0;
`ifdef DMEM_RANGE_CHECK_EN
         cap_err    <= 1'b0;
         o_data_err <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == IDLE && req) begin
            cap_idx   <= in_idx;
            cap_wdata <= i_data_wr;
            cap_be    <= i_data_be;
            cap_wr    <= i_data_wr_en;
            cap_oor   <= in_oor;
`ifdef DMEM_RANGE_CHECK_EN
            cap_err   <= in_err;
`endif
         end
         // Writes (including rd+wr) and dropped accesses return zero.
         if (commit_c) begin
            o_data_rd <= (acc_wr || acc_oor) ? '0 : mem[acc_idx];
         end
`ifdef DMEM_RANGE_CHECK_EN
         o_data_err <= commit_c & acc_err;
`endif
      end
   end

   // Array is not reset; a reset coincident with the commit edge discards the write.
   always_ff @(posedge clk) begin
      if (commit_c && !rst && acc_wr && !acc_oor) begin
         for (int k = 0; k < int'(NB); k++) begin
            if (acc_be[k]) begin
               mem[acc_idx][8*k +: 8] <= acc_wdata[8*k +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder: four instances with different wait states
// checked against an array-based memory model (honours DMEM_RANGE_CHECK_EN when defined).
module tb_dmem_responder;

   localparam int NI = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic [NI-1:0]        rd_en = '0;
   logic [NI-1:0]        wr_en = '0;
   logic [NI-1:0][31:0]  addr  = '0;
   logic [NI-1:0][31:0]  wdata = '0;
   logic [NI-1:0][3:0]   be    = '0;
   logic [NI-1:0][31:0]  rdata;
   logic [NI-1:0]        ready;
`ifdef DMEM_RANGE_CHECK_EN
   logic [NI-1:0]        err;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] ref_mem [NI][1024];
   bit          ref_vld [NI][1024];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int unsigned WS = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 15;
      dmem_responder #(.DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(WS)) u_dut (
         .clk          (clk),
         .rst          (rst),
         .i_data_rd_en (rd_en[g]),
         .i_data_wr_en (wr_en[g]),
         .i_data_addr  (addr[g]),
         .i_data_wr    (wdata[g]),
         .i_data_be    (be[g]),
         .o_data_rd    (rdata[g]),
`ifdef DMEM_RANGE_CHECK_EN
         .o_data_err   (err[g]),
`endif
         .o_data_ready (ready[g])
      );
   end

   function automatic int ws_of(input int i);
      case (i)
         0:       return 1;
         1:       return 0;
         2:       return 3;
         default: return 15;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Drives one access at the current point (just after a falling edge) and follows it to its ready pulse.
   // b2b: inputs are applied during the previous DONE cycle, adding one IDLE cycle to the latency.
   task automatic access(input int i, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b, input bit b2b);
      int          lat;
      int          widx;
      bit          oor;
      bit          known;
      logic [31:0] exp_rd;
      rd_en[i] = rd;
      wr_en[i] = wr;
      addr[i]  = a;
      wdata[i] = d;
      be[i]    = b;
      if (!b2b) begin
         #1;
         check("ready_low_on_req", 32'(ready[i]), 32'd0);
      end
      lat = 0;
      do begin
         @(negedge clk);
         #1;
         lat++;
      end while (!ready[i] && lat < 24);
      check($sformatf("latency_i%0d", i), 32'(lat), 32'(ws_of(i) + 1 + int'(b2b)));
      widx = int'(a >> 2) % 1024;
`ifdef DMEM_RANGE_CHECK_EN
      oor = (a >= 32'h1000);
`else
      oor = 1'b0;
`endif
      if (rd && !wr) begin
         exp_rd = oor ? 32'h0 : ref_mem[i][widx];
         known  = oor || ref_vld[i][widx];
      end else begin
         exp_rd = 32'h0;
         known  = rd && wr;
      end
      if (known) check($sformatf("rdata_i%0d_a%h", i, a), rdata[i], exp_rd);
`ifdef DMEM_RANGE_CHECK_EN
      check("err_done", 32'(err[i]), 32'(oor || (rd && wr)));
`endif
      if (wr && !oor) begin
         for (int k = 0; k < 4; k++)
            if (b[k]) ref_mem[i][widx][8*k +: 8] = d[8*k +: 8];
         if (b == 4'hF) ref_vld[i][widx] = 1'b1;
      end
      rd_en[i] = 1'b0;
      wr_en[i] = 1'b0;
   endtask

   // No requests anywhere: every instance must report ready continuously.
   task automatic idle(input int n);
      rd_en = '0;
      wr_en = '0;
      repeat (n) begin
         @(negedge clk);
         #1;
         for (int i = 0; i < NI; i++) check($sformatf("idle_ready_i%0d", i), 32'(ready[i]), 32'd1);
      end
   endtask

   initial begin
      // Reset state
      #2 rst = 1'b1;
      @(negedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         check("rst_ready", 32'(ready[i]), 32'd0);
         check("rst_rdata", rdata[i], 32'd0);
      end
      rst = 1'b0;
      idle(3);

      // Write then read
      access(0, 0, 1, 32'h10, 32'hCAFEBABE, 4'hF, 0);
      idle(1);
      access(0, 1, 0, 32'h10, 32'h0, 4'hF, 0);
      check("wr_rd_directed", rdata[0], 32'hCAFEBABE);

      // Byte lanes, including a be=0 no-op write
      idle(1);
      access(0, 0, 1, 32'h20, 32'h11223344, 4'hF, 0);
      access(0, 0, 1, 32'h20, 32'h00AA0000, 4'b0100, 1);
      access(0, 1, 0, 32'h22, 32'h0, 4'h0, 1);
      check("lanes_directed", rdata[0], 32'h11AA3344);
      access(0, 0, 1, 32'h20, 32'hFFFFFFFF, 4'b0000, 1);
      access(0, 1, 0, 32'h20, 32'h0, 4'hF, 1);
      check("be0_noop", rdata[0], 32'h11AA3344);

      // Latency sweep over the other instances
      for (int i = 1; i < NI; i++) begin
         idle(2);
         access(i, 0, 1, 32'h30, 32'h1000 + 32'(i), 4'hF, 0);
         idle(1);
         access(i, 1, 0, 32'h30, 32'h0, 4'hF, 0);
      end

      // Reset while the write is still in BUSY
      idle(1);
      access(2, 0, 1, 32'h40, 32'h01234567, 4'hF, 0);
      idle(1);
      rd_en[2] = 1'b0; wr_en[2] = 1'b1; addr[2] = 32'h40; wdata[2] = 32'hDEADBEEF; be[2] = 4'hF;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      wr_en[2] = 1'b0;
      #1;
      check("midrst_ready", 32'(ready[2]), 32'd0);
      check("midrst_rdata", rdata[2], 32'd0);
      @(negedge clk);
      #1;
      check("midrst_ready_hold", 32'(ready[2]), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle(1);
      access(2, 1, 0, 32'h40, 32'h0, 4'hF, 0);
      check("midrst_old_value", rdata[2], 32'h01234567);

      // Back-to-back alternating write/read with request held
      idle(1);
      access(0, 0, 1, 32'h0, 32'hA0A0A0A0, 4'hF, 0);
      access(0, 1, 0, 32'h0, 32'h0, 4'hF, 1);
      access(0, 0, 1, 32'h4, 32'hB1B1B1B1, 4'hF, 1);
      access(0, 1, 0, 32'h4, 32'h0, 4'hF, 1);
      access(0, 0, 1, 32'h8, 32'hC2C2C2C2, 4'hF, 1);
      access(0, 1, 0, 32'h8, 32'h0, 4'hF, 1);
      check("b2b_last", rdata[0], 32'hC2C2C2C2);

      // Out-of-range address: dropped with error, or wraps onto word 0
      access(0, 0, 1, 32'h0, 32'h0BADF00D, 4'hF, 1);
      access(0, 0, 1, 32'h1000, 32'h5A5A5A5A, 4'hF, 1);
      access(0, 1, 0, 32'h0, 32'h0, 4'hF, 1);
`ifdef DMEM_RANGE_CHECK_EN
      check("range_word0", rdata[0], 32'h0BADF00D);
`else
      check("wrap_word0", rdata[0], 32'h5A5A5A5A);
`endif

      // Randomized traffic on every instance
      for (int i = 0; i < NI; i++) begin
         idle(1);
         for (int j = 0; j < 8; j++) access(i, 0, 1, 32'h100 + 32'(4*j), $urandom, 4'hF, j != 0);
         for (int n = 0; n < 30; n++) begin
            logic [31:0] a;
            int          op;
            bit          b2b;
            a   = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | 32'h1000;
            op  = $urandom_range(0, 7);
            b2b = 1'($urandom_range(0, 1));
            if (!b2b) idle($urandom_range(1, 2));
            access(i, op < 4 || op == 7, op >= 4, a, $urandom, 4'($urandom), b2b);
         end
      end

      idle(2);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
